// File: rtl/lns_addsub_pipe_if.sv
// Operand/result/ROM bundle for lns_addsub_pipe. The optional LNS_FLAGS_EN
// macro adds the sticky overflow/underflow flags and their clear input.
interface lns_addsub_pipe_if #(
  parameter int LW = 16,
  parameter int AW = 15,
  parameter int DW = 15
);
  logic          in_valid;
  logic          in_ready;
  logic          op_sub;
  logic          a_sign;
  logic          b_sign;
  logic          a_zero;
  logic          b_zero;
  logic [LW-1:0] a_log;
  logic [LW-1:0] b_log;
  logic [AW-1:0] rom_plus_addr;
  logic [DW-1:0] rom_plus_data;
  logic [AW-1:0] rom_minus_addr;
  logic [DW-1:0] rom_minus_data;
  logic          out_valid;
  logic          out_ready;
  logic          z_sign;
  logic          z_zero;
  logic [LW-1:0] z_log;
`ifdef LNS_FLAGS_EN
  logic          flag_ovf;
  logic          flag_unf;
  logic          flag_clr;

  modport master (
    output in_valid, op_sub, a_sign, b_sign, a_zero, b_zero, a_log, b_log,
           rom_plus_data, rom_minus_data, out_ready, flag_clr,
    input  in_ready, rom_plus_addr, rom_minus_addr, out_valid, z_sign, z_zero,
           z_log, flag_ovf, flag_unf
  );
  modport slave (
    input  in_valid, op_sub, a_sign, b_sign, a_zero, b_zero, a_log, b_log,
           rom_plus_data, rom_minus_data, out_ready, flag_clr,
    output in_ready, rom_plus_addr, rom_minus_addr, out_valid, z_sign, z_zero,
           z_log, flag_ovf, flag_unf
  );
`else
  modport master (
    output in_valid, op_sub, a_sign, b_sign, a_zero, b_zero, a_log, b_log,
           rom_plus_data, rom_minus_data, out_ready,
    input  in_ready, rom_plus_addr, rom_minus_addr, out_valid, z_sign, z_zero,
           z_log
  );
  modport slave (
    input  in_valid, op_sub, a_sign, b_sign, a_zero, b_zero, a_log, b_log,
           rom_plus_data, rom_minus_data, out_ready,
    output in_ready, rom_plus_addr, rom_minus_addr, out_valid, z_sign, z_zero,
           z_log
  );
`endif
endinterface

// File: rtl/lns_addsub_pipe.sv
// 3-stage LNS add/subtract (Q5.11 log words) using external phi_plus/phi_minus ROMs.
// Optional sticky overflow/underflow flags when LNS_FLAGS_EN is defined.
module lns_addsub_pipe #(
  parameter int LW = 16,
  parameter int AW = 15,
  parameter int DW = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  lns_addsub_pipe_if.slave     bus
);
  // Handshake: an operand pair moves in when in_valid & in_ready, a result moves
  // out when out_valid & out_ready; in_ready = !out_valid | out_ready, so the whole
  // pipe advances or holds as one unit and never drops or repeats a result.
  localparam logic [LW-1:0] LOG_MAX = {1'b0, {(LW-1){1'b1}}};

  logic          w_adv;
  logic          w_bs, w_eff_sub, w_big_sign, w_byp, w_zero;
  logic [LW:0]   w_diff, w_neg;
  logic [LW-1:0] w_mag, w_big_log;

  logic          r_v1, r_eff_sub1, r_big_sign1, r_byp1, r_zero1;
  logic [LW-1:0] r_big_log1, r_mag1;

  logic          w_zero2, w_byp2;
  logic          r_v2, r_eff_sub2, r_big_sign2, r_byp2, r_zero2;
  logic [LW-1:0] r_big_log2;
  logic [DW-1:0] r_phi2;

  logic [LW:0]   w_big_ext, w_phi_ext, w_s;
  logic          w_ovf, w_unf, w_z_sign, w_z_zero;
  logic [LW-1:0] w_z_log;
  logic          r_v3, r_z_sign, r_z_zero;
  logic [LW-1:0] r_z_log;

  assign w_adv        = !r_v3 | bus.out_ready;
  assign bus.in_ready = w_adv;

  // S1: effective operation, ordering by log magnitude, zero-operand bypass
  always_comb begin
    w_bs       = bus.b_sign ^ bus.op_sub;
    w_eff_sub  = bus.a_sign ^ w_bs;
    w_diff     = {bus.a_log[LW-1], bus.a_log} - {bus.b_log[LW-1], bus.b_log};
    w_neg      = -w_diff;
    w_mag      = w_diff[LW] ? w_neg[LW-1:0] : w_diff[LW-1:0];
    w_big_log  = w_diff[LW] ? bus.b_log : bus.a_log;
    w_big_sign = w_diff[LW] ? w_bs : bus.a_sign;
    w_byp      = 1'b0;
    w_zero     = 1'b0;
    if (bus.a_zero && bus.b_zero) begin
      w_zero = 1'b1;
    end else if (bus.a_zero) begin
      w_big_log  = bus.b_log;
      w_big_sign = w_bs;
      w_byp      = 1'b1;
    end else if (bus.b_zero) begin
      w_big_log  = bus.a_log;
      w_big_sign = bus.a_sign;
      w_byp      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1        <= 1'b0;
      r_eff_sub1  <= 1'b0;
      r_big_sign1 <= 1'b0;
      r_byp1      <= 1'b0;
      r_zero1     <= 1'b0;
      r_big_log1  <= '0;
      r_mag1      <= '0;
    end else if (w_adv) begin
      r_v1        <= bus.in_valid;
      r_eff_sub1  <= w_eff_sub;
      r_big_sign1 <= w_big_sign;
      r_byp1      <= w_byp;
      r_zero1     <= w_zero;
      r_big_log1  <= w_big_log;
      r_mag1      <= w_mag;
    end
  end

  // S2: ROMs are read combinationally from the S1 registers, so the address holds on stall
  assign bus.rom_plus_addr  = r_mag1[AW-1:0];
  assign bus.rom_minus_addr = r_mag1[AW-1:0];
  assign w_zero2 = r_zero1 | (!r_byp1 & r_eff_sub1 & (r_mag1 == '0));
  assign w_byp2  = !w_zero2 & (r_byp1 | (|r_mag1[LW-1:AW]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2        <= 1'b0;
      r_eff_sub2  <= 1'b0;
      r_big_sign2 <= 1'b0;
      r_byp2      <= 1'b0;
      r_zero2     <= 1'b0;
      r_big_log2  <= '0;
      r_phi2      <= '0;
    end else if (w_adv) begin
      r_v2        <= r_v1;
      r_eff_sub2  <= r_eff_sub1;
      r_big_sign2 <= r_big_sign1;
      r_byp2      <= w_byp2;
      r_zero2     <= w_zero2;
      r_big_log2  <= r_big_log1;
      r_phi2      <= r_eff_sub1 ? bus.rom_minus_data : bus.rom_plus_data;
    end
  end

  // S3: one extra bit of headroom; the top two bits disagreeing means out of Q5.11 range
  always_comb begin
    w_big_ext = {r_big_log2[LW-1], r_big_log2};
    w_phi_ext = {{(LW+1-DW){1'b0}}, r_phi2};
    w_s       = r_eff_sub2 ? (w_big_ext - w_phi_ext) : (w_big_ext + w_phi_ext);
    w_ovf     = !r_zero2 & !r_byp2 & !w_s[LW] &  w_s[LW-1];
    w_unf     = !r_zero2 & !r_byp2 &  w_s[LW] & !w_s[LW-1];
    w_z_sign  = r_big_sign2;
    w_z_zero  = 1'b0;
    w_z_log   = w_s[LW-1:0];
    if (r_zero2 || w_unf) begin
      w_z_sign = 1'b0;
      w_z_zero = 1'b1;
      w_z_log  = '0;
    end else if (r_byp2) begin
      w_z_log = r_big_log2;
    end else if (w_ovf) begin
      w_z_log = LOG_MAX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v3     <= 1'b0;
      r_z_sign <= 1'b0;
      r_z_zero <= 1'b0;
      r_z_log  <= '0;
    end else if (w_adv) begin
      r_v3     <= r_v2;
      r_z_sign <= w_z_sign;
      r_z_zero <= w_z_zero;
      r_z_log  <= w_z_log;
    end
  end

  assign bus.out_valid = r_v3;
  assign bus.z_sign    = r_z_sign;
  assign bus.z_zero    = r_z_zero;
  assign bus.z_log     = r_z_log;

`ifdef LNS_FLAGS_EN
  logic r_ovf3, r_unf3, r_flag_ovf, r_flag_unf;

  // Flags set only when the flagged result actually leaves; a same-cycle set beats clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf3     <= 1'b0;
      r_unf3     <= 1'b0;
      r_flag_ovf <= 1'b0;
      r_flag_unf <= 1'b0;
    end else begin
      if (w_adv) begin
        r_ovf3 <= w_ovf;
        r_unf3 <= w_unf;
      end
      if (bus.flag_clr) begin
        r_flag_ovf <= 1'b0;
        r_flag_unf <= 1'b0;
      end
      if (r_v3 && bus.out_ready && r_ovf3) r_flag_ovf <= 1'b1;
      if (r_v3 && bus.out_ready && r_unf3) r_flag_unf <= 1'b1;
    end
  end

  assign bus.flag_ovf = r_flag_ovf;
  assign bus.flag_unf = r_flag_unf;
`endif
endmodule
